spi_master: RTL and testbench

Frame-level SPI master for the 10-bit SPI link: the initiator that drives `SCLK`, `SS` and `MOSI` toward `SPI_slave` and captures its `MISO` reply. Sits between the host-side control logic (which supplies a word and a start strobe) and the board-level SPI pins. It generates a divided serial clock from the system clock, shifts one `FRAME_W`-bit word out MSB-first while shifting the reply in, and reports completion with a single-cycle `done` pulse.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_div.sv | 28 ++
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame width and master FSM state encoding.
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_c fires on the CLK_DIV-th cycle after
// enable or restart, then every CLK_DIV cycles while enabled.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));

  // Count cycles within the current half-period; wrap on tick.
  always_ff @(posedge clk) begin
    if (rst || !en || restart || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Frame-level SPI master: shifts one FRAME_W-bit word out MSB-first on MOSI
// while capturing MISO, and pulses done when SS drops.
// Optional build macro: SPI_MASTER_ECHO_CHECK_EN enables the inverted-echo
// check on echo_err; without it echo_err is tied low.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W = SPI_FRAME_W,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               MISO,
  output logic               SCLK,
  output logic               SS,
  output logic               MOSI,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_data,
  output logic               echo_err
);

  localparam int unsigned BIT_W = $clog2(FRAME_W + 1);

  spi_state_t         state, state_d;
  logic [FRAME_W-1:0] tx_sr, tx_sr_d;
  logic [FRAME_W-1:0] rx_sr, rx_sr_d;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [FRAME_W-1:0] rx_data_d;
  logic               sclk_d, ss_d, mosi_d, busy_d, done_d;
  logic               tick_c;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .restart (state_d != state),
    .tick_c  (tick_c)
  );

  // Next-state and next-output logic; everything holds unless a tick moves it.
  always_comb begin
    state_d   = state;
    tx_sr_d   = tx_sr;
    rx_sr_d   = rx_sr;
    bit_cnt_d = bit_cnt;
    rx_data_d = rx_data;
    sclk_d    = SCLK;
    ss_d      = SS;
    mosi_d    = MOSI;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          ss_d      = 1'b1;
          busy_d    = 1'b1;
          mosi_d    = tx_data[FRAME_W-1];
          state_d   = SETUP;
        end
      end
      SETUP, LOW: begin
        if (tick_c) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick_c) begin
          sclk_d  = 1'b0;
          rx_sr_d = {rx_sr[FRAME_W-2:0], MISO};
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            state_d = HOLD;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
            tx_sr_d   = {tx_sr[FRAME_W-2:0], 1'b0};
            mosi_d    = tx_sr[FRAME_W-2];
            state_d   = LOW;
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          ss_d      = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      SCLK    <= 1'b0;
      SS      <= 1'b0;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      tx_sr   <= tx_sr_d;
      rx_sr   <= rx_sr_d;
      bit_cnt <= bit_cnt_d;
      rx_data <= rx_data_d;
      SCLK    <= sclk_d;
      SS      <= ss_d;
      MOSI    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef SPI_MASTER_ECHO_CHECK_EN
  logic [FRAME_W-1:0] tx_lat;

  // Keep the accepted word and flag a reply that is not its inverse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_lat   <= '0;
      echo_err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        tx_lat <= tx_data;
      end
      if (done_d) begin
        echo_err <= (rx_sr != ~tx_lat);
      end
    end
  end
`else
  assign echo_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural echo slave.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned FW = SPI_FRAME_W;
  localparam int unsigned CD = 2;
  localparam int LAT = 1 + CD * (2 * FW + 1);

  logic          clk = 1'b0;
  logic          rst, start;
  logic [FW-1:0] tx_data;
  logic          MISO, SCLK, SS, MOSI, busy, done, echo_err;
  logic [FW-1:0] rx_data;

  spi_master #(.FRAME_W(FW), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .MISO     (MISO),
    .SCLK     (SCLK),
    .SS       (SS),
    .MOSI     (MOSI),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .echo_err (echo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] tx;
    logic [FW-1:0] rx;
    logic          echo;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            t0 = 0;
  int            rises = 0;
  logic [FW-1:0] mosi_sh = '0;
  logic          miso_q = 1'b0;
  bit            stuck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: registers inverted MOSI on each SCLK rise; also log MOSI bits.
  always @(posedge SCLK) begin
    miso_q  <= ~MOSI;
    mosi_sh <= {mosi_sh[FW-2:0], MOSI};
    rises   <= rises + 1;
  end
  assign MISO = stuck ? 1'b0 : miso_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [FW-1:0] tx);
    exp_t e;
    e.tx = tx;
    e.rx = stuck ? '0 : ~tx;
`ifdef SPI_MASTER_ECHO_CHECK_EN
    e.echo = (e.rx != ~tx);
`else
    e.echo = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: every done must match the oldest accepted frame.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_done", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.rx));
        chk("echo_err", 32'(echo_err), 32'(e.echo));
        chk("mosi_bits", 32'(mosi_sh), 32'(e.tx));
        chk("ss_at_done", 32'(SS), 32'(0));
        chk("busy_at_done", 32'(busy), 32'(0));
      end
    end
  end

  // Assert start at a negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [FW-1:0] tx);
    tx_data = tx;
    start   = 1'b1;
    sb.push_back(mk(tx));
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; latency counts edges from the start-sampling edge.
  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk({tag, "_timeout"}, 32'(0), 32'(1));
    else               chk({tag, "_lat"}, 32'(cyc - t0 + 1), 32'(LAT));
  endtask

  initial begin
    int  r0;
    logic any;
    rst = 1'b1; start = 1'b0; tx_data = '0;

    // Reset defaults and idle quiet.
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({SCLK, SS, MOSI, busy, done, echo_err}), 32'(0));
    chk("rst_rx", 32'(rx_data), 32'(0));
    rst = 1'b0;
    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any = any | SCLK | SS | MOSI;
    end
    chk("idle_quiet", 32'(any), 32'(0));

    // Single frame with looped inverted echo.
    r0 = rises;
    launch(10'h2B5);
    chk("ss_first", 32'(SS), 32'(1));
    chk("mosi_first", 32'(MOSI), 32'(1));
    chk("busy_first", 32'(busy), 32'(1));
    wait_done("f1");
    chk("rx_2b5", 32'(rx_data), 32'(10'h14A));
    chk("rises_f1", 32'(rises - r0), 32'(FW));

    // Start during a frame is ignored and not queued.
    repeat (4) @(negedge clk);
    r0 = rises;
    launch(10'h0C3);
    repeat (9) @(negedge clk);
    tx_data = 10'h3FF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any = any | busy | SS;
    end
    chk("ign_no_2nd", 32'(any), 32'(0));
    chk("rises_ign", 32'(rises - r0), 32'(FW));

    // Back-to-back: start held through done.
    r0 = rises;
    tx_data = 10'h155;
    start   = 1'b1;
    sb.push_back(mk(10'h155));
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    tx_data = 10'h2AA;
    wait_done("b2b1");
    sb.push_back(mk(10'h2AA));
    @(negedge clk);
    chk("b2b_ss", 32'(SS), 32'(1));
    t0 = cyc;
    start = 1'b0;
    wait_done("b2b2");
    chk("rises_b2b", 32'(rises - r0), 32'(2 * FW));

    // Reset mid-frame at edge 20, then a clean frame.
    repeat (3) @(negedge clk);
    launch(10'h0F0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("mid_rst_outs", 32'({SCLK, SS, MOSI, busy, done}), 32'(0));
    chk("mid_rst_rx", 32'(rx_data), 32'(0));
    rst = 1'b0;
    repeat (50) @(negedge clk);
    launch(10'h1E7);
    wait_done("after_rst");

    // Stuck MISO: reply all zeros.
    repeat (3) @(negedge clk);
    stuck = 1'b1;
    launch(10'h000);
    wait_done("stuck");
    chk("rx_stuck", 32'(rx_data), 32'(0));
`ifdef SPI_MASTER_ECHO_CHECK_EN
    chk("echo_stuck", 32'(echo_err), 32'(1));
`else
    chk("echo_stuck", 32'(echo_err), 32'(0));
`endif
    stuck = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
